// File: rtl/lab2_proc_squash_fetch_buffer.sv
// ============================================================================
// lab2_proc_squash_fetch_buffer
//   Credit-gated imem fetch buffer that drops every response of a squashed fetch.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module lab2_proc_squash_fetch_buffer #(
   parameter int p_msg_nbits   = 39,
   parameter int p_num_entries = 4,
   parameter bit p_bypass      = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 squash,
   input  logic                                 req_val,
   output logic                                 req_rdy,
   output logic                                 mem_req_val,
   input  logic                                 mem_req_rdy,
   input  logic [p_msg_nbits-1:0]               istream_msg,
   input  logic                                 istream_val,
   output logic                                 istream_rdy,
   output logic [p_msg_nbits-1:0]               ostream_msg,
   output logic                                 ostream_val,
   input  logic                                 ostream_rdy,
   output logic [$clog2(p_num_entries+1)-1:0]   num_inflight,
   output logic [$clog2(p_num_entries+1)-1:0]   num_dropping
);

   localparam int c_cnt_w = $clog2(p_num_entries + 1);
   localparam int c_ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

   logic [c_cnt_w-1:0]     r_inflight;
   logic [c_cnt_w-1:0]     r_drop_cnt;
   logic [c_cnt_w-1:0]     r_count;
   logic [c_ptr_w-1:0]     r_head;
   logic [c_ptr_w-1:0]     r_tail;
   logic [p_msg_nbits-1:0] r_mem [p_num_entries];

   logic [c_cnt_w:0]       w_occupancy;
   logic                   w_credit;
   logic                   w_req_fire;
   logic                   w_resp_fire;
   logic                   w_drop;
   logic                   w_bypass_en;
   logic                   w_bypass;
   logic                   w_enq;
   logic                   w_deq;

   // Pointers wrap at p_num_entries, which need not be a power of two.
   function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(p_num_entries - 1)) ? '0 : p + 1'b1;
   endfunction

   generate
      if (p_bypass) begin : g_bypass
         assign w_bypass_en = 1'b1;
      end else begin : g_no_bypass
         assign w_bypass_en = 1'b0;
      end
   endgenerate

   assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
   assign w_credit    = w_occupancy < (c_cnt_w + 1)'(p_num_entries);

   assign mem_req_val = !reset & req_val & w_credit;
   assign req_rdy     = !reset & mem_req_rdy & w_credit;
   assign istream_rdy = !reset;

   assign w_req_fire  = req_val & req_rdy;
   assign w_resp_fire = istream_val & !reset;
   assign w_drop      = squash | (r_drop_cnt != '0);
   assign w_bypass    = w_bypass_en & (r_count == '0) & ostream_rdy & !w_drop;
   assign w_enq       = w_resp_fire & !w_drop & !w_bypass;

   assign ostream_val = !reset & !squash &
                        ((r_count != '0) | (w_bypass_en & istream_val & (r_drop_cnt == '0)));
   assign ostream_msg = (r_count != '0) ? r_mem[r_head] : istream_msg;
   assign w_deq       = ostream_val & ostream_rdy & (r_count != '0);

   assign num_inflight = r_inflight;
   assign num_dropping = r_drop_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         r_inflight <= r_inflight + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp_fire);
         // A squash marks everything already in flight except a response landing now.
         if (squash) begin
            r_drop_cnt <= r_inflight - c_cnt_w'(w_resp_fire);
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
         end else begin
            r_drop_cnt <= r_drop_cnt - c_cnt_w'(w_resp_fire & (r_drop_cnt != '0));
            r_count    <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
            if (w_enq) r_tail <= f_ptr_inc(r_tail);
            if (w_deq) r_head <= f_ptr_inc(r_head);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_tail] <= istream_msg;
   end

   always_ff @(posedge clk) begin
      if (!reset && istream_val)
         assert (r_inflight != '0) else $error("imem response arrived with nothing in flight");
   end

endmodule

`default_nettype wire
